// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous VRAM between VGA scan-out
// fetches (absolute priority), a one-entry posted CPU write buffer, and CPU
// reads issued in otherwise free slots.
// Optional feature macro: VRAM_ARB_STATS_EN adds stall_count / stats_clr.
module vram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]       stall_count,
  input  logic              stats_clr
`endif
);

  typedef enum logic [1:0] {C_IDLE, C_RD_WAIT, C_WR_ACK} cstate_t;

  cstate_t           state, state_nxt;
  logic              wb_full;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              drain, capture, rd_issue;
  logic              vld_p1;

`ifdef VRAM_ARB_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  // CPU FSM next state, slot decisions and ack generation
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    rd_issue  = 1'b0;
    cpu_ack   = 1'b0;
    drain     = wb_full & ~vga_req;
    case (state)
      C_IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            // A drain in the same cycle frees the entry for the new write
            if (!wb_full || drain) begin
              capture   = 1'b1;
              state_nxt = C_WR_ACK;
            end
          end else if (!wb_full && !vga_req) begin
            // Reads wait for an empty buffer so they never see stale data
            rd_issue  = 1'b1;
            state_nxt = C_RD_WAIT;
          end
        end
      end
      C_RD_WAIT: begin
        cpu_ack   = 1'b1;
        state_nxt = C_IDLE;
      end
      C_WR_ACK: begin
        cpu_ack   = 1'b1;
        state_nxt = C_IDLE;
      end
      default: state_nxt = C_IDLE;
    endcase
  end

  // RAM port mux: VGA, then write-buffer drain, then CPU read; quiet in reset
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (!reset) begin
      if (vga_req) begin
        ram_addr = vga_addr;
      end else if (wb_full) begin
        ram_addr  = wb_addr;
        ram_we    = 1'b1;
        ram_wdata = wb_data;
      end else if (rd_issue) begin
        ram_addr = cpu_addr;
      end
    end
  end

  // Read data is forwarded straight from the RAM in the cycle after the address
  always_comb begin
    vga_rvalid = vld_p1;
    vga_rdata  = vld_p1 ? ram_rdata : '0;
    cpu_rdata  = (state == C_RD_WAIT) ? ram_rdata : '0;
  end

  // CPU FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= C_IDLE;
    else       state <= state_nxt;
  end

  // Write-buffer full flag: set on capture, cleared on a drain without refill
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        wb_full <= 1'b0;
    else if (capture) wb_full <= 1'b1;
    else if (drain)   wb_full <= 1'b0;
  end

  // Write-buffer payload; qualified by wb_full so it needs no reset
  always_ff @(posedge clk) begin
    if (capture) begin
      wb_addr <= cpu_addr;
      wb_data <= cpu_wdata;
    end
  end

  // ---- stage p0 -> p1: VGA fetch valid follows the RAM read latency ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= vga_req;
  end

`ifdef VRAM_ARB_STATS_EN
  // Stall counter: CPU waiting in idle with no slot granted; clear wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          stall_count <= 16'd0;
    else if (stats_clr) stall_count <= 16'd0;
    else if (cpu_req && state == C_IDLE && !capture && !rd_issue)
      stall_count <= sat_inc(stall_count);
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed table-driven bench for vram_arbiter with a
// behavioural synchronous RAM. Stall counter checks apply with VRAM_ARB_STATS_EN.
module tb_vram_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0]       stall_count;
  logic              stats_clr;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .vga_req    (vga_req),
    .vga_addr   (vga_addr),
    .vga_rvalid (vga_rvalid),
    .vga_rdata  (vga_rdata),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
`ifdef VRAM_ARB_STATS_EN
    ,
    .stall_count(stall_count),
    .stats_clr  (stats_clr)
`endif
  );

  // Synchronous single-port RAM model; 0x0010 and 0x0011 are fixed preloads
  bit [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_addr == 13'h0010)      ram_rdata <= 16'hBEEF;
    else if (ram_addr == 13'h0011) ram_rdata <= 16'hCAFE;
    else                           ram_rdata <= mem[ram_addr];
  end

  typedef struct {
    logic              vreq;
    logic [ADDR_W-1:0] vaddr;
    logic              creq;
    logic              cwe;
    logic [ADDR_W-1:0] caddr;
    logic [DATA_W-1:0] cwd;
    logic              rv;
    logic [DATA_W-1:0] vrd;
    logic              ack;
    logic [DATA_W-1:0] crd;
    logic              we;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rwd;
  } vec_t;

  function automatic vec_t mk(
    input logic vreq, input logic [ADDR_W-1:0] vaddr,
    input logic creq, input logic cwe, input logic [ADDR_W-1:0] caddr,
    input logic [DATA_W-1:0] cwd,
    input logic rv, input logic [DATA_W-1:0] vrd,
    input logic ack, input logic [DATA_W-1:0] crd,
    input logic we, input logic [ADDR_W-1:0] ra, input logic [DATA_W-1:0] rwd);
    vec_t v;
    v.vreq = vreq; v.vaddr = vaddr; v.creq = creq; v.cwe = cwe;
    v.caddr = caddr; v.cwd = cwd; v.rv = rv; v.vrd = vrd; v.ack = ack;
    v.crd = crd; v.we = we; v.ra = ra; v.rwd = rwd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive on the falling edge, compare shortly after
  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    vga_req   = v.vreq;
    vga_addr  = v.vaddr;
    cpu_req   = v.creq;
    cpu_we    = v.cwe;
    cpu_addr  = v.caddr;
    cpu_wdata = v.cwd;
    #2;
    chk({tag, ".vga_rvalid"}, {31'd0, vga_rvalid}, {31'd0, v.rv});
    chk({tag, ".vga_rdata"},  {16'd0, vga_rdata},  {16'd0, v.vrd});
    chk({tag, ".cpu_ack"},    {31'd0, cpu_ack},    {31'd0, v.ack});
    chk({tag, ".cpu_rdata"},  {16'd0, cpu_rdata},  {16'd0, v.crd});
    chk({tag, ".ram_we"},     {31'd0, ram_we},     {31'd0, v.we});
    chk({tag, ".ram_addr"},   {19'd0, ram_addr},   {19'd0, v.ra});
    chk({tag, ".ram_wdata"},  {16'd0, ram_wdata},  {16'd0, v.rwd});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".vga_rvalid"}, {31'd0, vga_rvalid}, 32'd0);
    chk({tag, ".vga_rdata"},  {16'd0, vga_rdata},  32'd0);
    chk({tag, ".cpu_ack"},    {31'd0, cpu_ack},    32'd0);
    chk({tag, ".cpu_rdata"},  {16'd0, cpu_rdata},  32'd0);
    chk({tag, ".ram_we"},     {31'd0, ram_we},     32'd0);
    chk({tag, ".ram_addr"},   {19'd0, ram_addr},   32'd0);
    chk({tag, ".ram_wdata"},  {16'd0, ram_wdata},  32'd0);
`ifdef VRAM_ARB_STATS_EN
    chk({tag, ".stall_count"}, {16'd0, stall_count}, 32'd0);
`endif
  endtask

  vec_t tbl [13];
  vec_t idle;

  initial begin
    reset = 1'b1; vga_req = 1'b0; vga_addr = '0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = '0; cpu_wdata = '0;
`ifdef VRAM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    idle = mk(0,13'h0, 0,0,13'h0,16'h0, 0,16'h0, 0,16'h0, 0,13'h0,16'h0);

    // Basic traffic table
    tbl[0]  = idle;
    tbl[1]  = mk(1,13'h010, 0,0,13'h000,16'h0000, 0,16'h0000, 0,16'h0000, 0,13'h010,16'h0000);
    tbl[2]  = mk(1,13'h011, 0,0,13'h000,16'h0000, 1,16'hBEEF, 0,16'h0000, 0,13'h011,16'h0000);
    tbl[3]  = mk(0,13'h000, 0,0,13'h000,16'h0000, 1,16'hCAFE, 0,16'h0000, 0,13'h000,16'h0000);
    tbl[4]  = mk(0,13'h000, 1,1,13'h100,16'h1234, 0,16'h0000, 0,16'h0000, 0,13'h000,16'h0000);
    tbl[5]  = mk(0,13'h000, 1,1,13'h100,16'h1234, 0,16'h0000, 1,16'h0000, 1,13'h100,16'h1234);
    tbl[6]  = idle;
    tbl[7]  = mk(0,13'h000, 1,0,13'h100,16'h0000, 0,16'h0000, 0,16'h0000, 0,13'h100,16'h0000);
    tbl[8]  = mk(0,13'h000, 1,0,13'h100,16'h0000, 0,16'h0000, 1,16'h1234, 0,13'h000,16'h0000);
    tbl[9]  = idle;
    tbl[10] = mk(1,13'h010, 1,1,13'h300,16'hA5A5, 0,16'h0000, 0,16'h0000, 0,13'h010,16'h0000);
    tbl[11] = mk(0,13'h000, 1,1,13'h300,16'hA5A5, 1,16'hBEEF, 1,16'h0000, 1,13'h300,16'hA5A5);
    tbl[12] = idle;

    // Reset state
    repeat (2) @(negedge clk);
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) step(tbl[i], $sformatf("tbl%0d", i));

    // CPU read stalled behind a 20-cycle VGA burst
`ifdef VRAM_ARB_STATS_EN
    stats_clr = 1'b1;
`endif
    step(idle, "stall_pre");
`ifdef VRAM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    for (int i = 0; i < 20; i++)
      step(mk(1,13'h010, 1,0,13'h100,16'h0, (i > 0), (i > 0) ? 16'hBEEF : 16'h0000,
              0,16'h0, 0,13'h010,16'h0), $sformatf("burst%0d", i));
    step(mk(0,13'h000, 1,0,13'h100,16'h0, 1,16'hBEEF, 0,16'h0000, 0,13'h100,16'h0), "burst_issue");
    step(mk(0,13'h000, 1,0,13'h100,16'h0, 0,16'h0000, 1,16'h1234, 0,13'h000,16'h0), "burst_ack");
`ifdef VRAM_ARB_STATS_EN
    chk("stall_count_20", {16'd0, stall_count}, 32'd20);
    stats_clr = 1'b1;
`endif
    step(idle, "clr");
`ifdef VRAM_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    step(idle, "clr_after");
`ifdef VRAM_ARB_STATS_EN
    chk("stall_count_clr", {16'd0, stall_count}, 32'd0);
`endif

    // Write then read of the same word while VGA owns the port
    step(mk(1,13'h010, 1,1,13'h200,16'h5555, 0,16'h0000, 0,16'h0000, 0,13'h010,16'h0000), "wr_rd1");
    step(mk(1,13'h010, 1,1,13'h200,16'h5555, 1,16'hBEEF, 1,16'h0000, 0,13'h010,16'h0000), "wr_rd2");
    for (int i = 0; i < 3; i++)
      step(mk(1,13'h010, 1,0,13'h200,16'h0, 1,16'hBEEF, 0,16'h0, 0,13'h010,16'h0),
           $sformatf("wr_rd_wait%0d", i));
    step(mk(0,13'h000, 1,0,13'h200,16'h0, 1,16'hBEEF, 0,16'h0000, 1,13'h200,16'h5555), "wr_rd_drain");
    step(mk(0,13'h000, 1,0,13'h200,16'h0, 0,16'h0000, 0,16'h0000, 0,13'h200,16'h0000), "wr_rd_issue");
    step(mk(0,13'h000, 1,0,13'h200,16'h0, 0,16'h0000, 1,16'h5555, 0,13'h000,16'h0000), "wr_rd_ack");
    step(idle, "wr_rd_idle");

    // Two writes behind continuous VGA: drain and second capture coincide
    step(mk(1,13'h010, 1,1,13'h400,16'h1111, 0,16'h0000, 0,16'h0, 0,13'h010,16'h0000), "ww1");
    step(mk(1,13'h010, 1,1,13'h400,16'h1111, 1,16'hBEEF, 1,16'h0, 0,13'h010,16'h0000), "ww2");
    step(mk(1,13'h010, 1,1,13'h401,16'h2222, 1,16'hBEEF, 0,16'h0, 0,13'h010,16'h0000), "ww3");
    step(mk(1,13'h010, 1,1,13'h401,16'h2222, 1,16'hBEEF, 0,16'h0, 0,13'h010,16'h0000), "ww4");
    step(mk(0,13'h000, 1,1,13'h401,16'h2222, 1,16'hBEEF, 0,16'h0, 1,13'h400,16'h1111), "ww5");
    step(mk(0,13'h000, 1,1,13'h401,16'h2222, 0,16'h0000, 1,16'h0, 1,13'h401,16'h2222), "ww6");
    step(idle, "ww7");
    chk("ww_mem400", {16'd0, 16'(mem[13'h400])}, 32'h1111);
    chk("ww_mem401", {16'd0, 16'(mem[13'h401])}, 32'h2222);

    // Reset one cycle after a write capture with a VGA fetch in flight
    step(mk(1,13'h010, 1,1,13'h500,16'h7777, 0,16'h0000, 0,16'h0, 0,13'h010,16'h0000), "rst_cap");
    @(negedge clk);
    reset = 1'b1; vga_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    #2;
    chk_all_zero("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    step(idle, "rst_after1");
    step(idle, "rst_after2");
    chk("rst_mem500", {16'd0, 16'(mem[13'h500])}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
